// File: rtl/mem_wbfifo_drain.sv
// Write-back FIFO: queues dirty cache lines and drains each one to DRAM as MW-bit beats
// over a wren/ack handshake. Optional line-address probe enabled by macro WBFIFO_PROBE_EN.
module mem_wbfifo_drain #(
  parameter int LOG2WBDATAWIDTH  = 9,
  parameter int LOG2MEMDATAWIDTH = 7,
  parameter int LOG2DEPTH        = 2
) (
  input  logic                              mem_clk,
  input  logic                              resetn,
  input  logic [31:0]                       wbaddr,
  input  logic [(2**LOG2WBDATAWIDTH)-1:0]   wbdata,
  input  logic                              wbwe,
  output logic                              wbfull,
  output logic                              wb_overflow,
  output logic [31:0]                       mem_address,
  output logic [(2**LOG2MEMDATAWIDTH)-1:0]  mem_writedata,
  output logic                              mem_wren,
  input  logic                              mem_ack,
  input  logic [31:0]                       probe_addr,
  output logic                              probe_hit,
  output logic                              dbg_state_o,
  output logic [LOG2DEPTH:0]                dbg_count_o
);

  localparam int WBW   = 2 ** LOG2WBDATAWIDTH;
  localparam int MW    = 2 ** LOG2MEMDATAWIDTH;
  localparam int DEPTH = 2 ** LOG2DEPTH;
  localparam int BEATS = 2 ** (LOG2WBDATAWIDTH - LOG2MEMDATAWIDTH);
  localparam int LB    = LOG2WBDATAWIDTH - 3;
  localparam int MB    = LOG2MEMDATAWIDTH - 3;
  localparam int TAGW  = 32 - LB;
  localparam int BW    = (LOG2WBDATAWIDTH > LOG2MEMDATAWIDTH) ?
                         (LOG2WBDATAWIDTH - LOG2MEMDATAWIDTH) : 1;

  // Handshake: a beat is offered while mem_wren=1 and is consumed on any edge where
  // mem_ack=1; address/data hold until then, and mem_ack with mem_wren=0 does nothing.
  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  logic [TAGW-1:0]      tag_q  [DEPTH];
  logic [WBW-1:0]       data_q [DEPTH];
  logic [LOG2DEPTH-1:0] head_q;
  logic [LOG2DEPTH-1:0] tail_q;
  logic [LOG2DEPTH:0]   count_q;
  logic [LOG2DEPTH:0]   count_d;
  logic [BW-1:0]        beat_q;
  state_t               state_q;
  logic                 overflow_q;

  logic push;
  logic pop;
  logic last_beat;
  logic unused_wb_lo;

  assign unused_wb_lo = ^wbaddr[LB-1:0];

  // Full is judged on the registered count, so a pop in the same cycle cannot admit a push.
  assign wbfull    = (count_q == (LOG2DEPTH+1)'(DEPTH));
  assign push      = wbwe & ~wbfull;
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign pop       = (state_q == XFER) & mem_ack & last_beat;
  assign count_d   = count_q + (LOG2DEPTH+1)'(push) - (LOG2DEPTH+1)'(pop);

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) tail_q <= tail_q + LOG2DEPTH'(1);
      if (wbwe && wbfull) overflow_q <= 1'b1;
      case (state_q)
        IDLE: if (count_q != '0) state_q <= XFER;
        XFER: begin
          if (mem_ack) begin
            if (last_beat) begin
              beat_q <= '0;
              head_q <= head_q + LOG2DEPTH'(1);
              if (count_d == '0) state_q <= IDLE;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge mem_clk) begin
    if (push) begin
      tag_q[tail_q]  <= wbaddr[31:LB];
      data_q[tail_q] <= wbdata;
    end
  end

  assign mem_wren      = (state_q == XFER);
  assign mem_address   = {tag_q[head_q], {LB{1'b0}}} + (32'(beat_q) << MB);
  assign mem_writedata = data_q[head_q][beat_q*MW +: MW];
  assign wb_overflow   = overflow_q;
  assign dbg_state_o   = state_q;
  assign dbg_count_o   = count_q;

`ifdef WBFIFO_PROBE_EN
  logic [LOG2DEPTH-1:0] probe_off;
  logic                 unused_probe_lo;

  assign unused_probe_lo = ^probe_addr[LB-1:0];

  // An entry is live when its distance from head is below count; the head line stays
  // live until the edge that pops it.
  always_comb begin
    probe_hit = 1'b0;
    probe_off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      probe_off = LOG2DEPTH'(i) - head_q;
      if (({1'b0, probe_off} < count_q) && (tag_q[i] == probe_addr[31:LB]))
        probe_hit = 1'b1;
    end
  end
`else
  logic unused_probe;

  assign unused_probe = ^probe_addr;
  assign probe_hit    = 1'b0;
`endif

endmodule
